frame_sequencer: RTL and testbench
==================================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameter FRAME_PERIOD, default 1666667: clk cycles per frame tick (60 Hz at 100 MHz).
REQ-002 SHALL have parameter CNT_W, default 21: tick counter width; must satisfy 2^CNT_W > FRAME_PERIOD.
REQ-003 SHALL have port clk  in  1: single clock, 100 MHz domain.
REQ-004 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-005 SHALL have port enable  in  1: level; allows frame ticks.
REQ-006 SHALL have port vsync  in  1: display vsync, active-high, asynchronous to clk.
REQ-007 SHALL have port raster_done  in  1: rasterizer finished frame, level or pulse.
REQ-008 SHALL have port swap_ack  in  1: framebuffer accepted buffer swap.
REQ-009 SHALL have port frame_start  out  1: one-cycle pulse to clipper/rasterizer.
REQ-010 SHALL have port swap_req  out  1: buffer-swap request, held until acked.
REQ-011 SHALL have port front_sel  out  1: index of displayed buffer.
REQ-012 SHALL have port busy  out  1: high whenever state != IDLE.
REQ-013 SHALL have port overrun  out  1: one-cycle pulse on dropped tick.

Function
REQ-014 Tick counter SHALL count 0..FRAME_PERIOD-1 while enable=1, wrap to 0 and assert internal tick in the cycle count==FRAME_PERIOD-1; enable=0 SHALL clear the counter to 0 and suppress tick.
REQ-015 FSM states SHALL be IDLE, START, RENDER, WAIT_VSYNC, SWAP.
REQ-016 IDLE->START on tick; START->RENDER unconditionally after one cycle; RENDER->WAIT_VSYNC when raster_done=1; WAIT_VSYNC->SWAP on synchronized vsync rising edge; SWAP->IDLE when swap_ack=1.
REQ-017 frame_start SHALL be high exactly the one cycle spent in START, i.e. the cycle after tick.
REQ-018 raster_done SHALL be sampled only in RENDER; ignored elsewhere.
REQ-019 vsync SHALL pass a 2-flop synchronizer plus edge register; a rising edge SHALL be acted on within 3 clk cycles; edges outside WAIT_VSYNC SHALL be discarded, never queued.
REQ-020 swap_req SHALL equal (state==SWAP); swap_ack outside SWAP SHALL be ignored.
REQ-021 front_sel SHALL toggle on the clock edge leaving SWAP with swap_ack=1, and only then.
REQ-022 Tick while state != IDLE SHALL be dropped and pulse overrun for one cycle; no frame_start results.
REQ-023 Tick in the same cycle as SWAP->IDLE SHALL count as dropped (state not IDLE that cycle).
REQ-024 Deasserting enable mid-frame SHALL NOT abort the frame; FSM completes to IDLE.

Reset
REQ-025 rst SHALL asynchronously force state=IDLE, counter=0, synchronizer flops=0, frame_start=0, swap_req=0, busy=0, overrun=0, front_sel=0.
REQ-026 rst mid-frame SHALL abandon the frame with no swap_req; first post-reset tick SHALL occur FRAME_PERIOD cycles after release with enable=1.

Configuration
REQ-027 With FRAME_SEQ_STATS_EN defined: outputs frame_count[15:0] (increments on each swap_ack completion) and drop_count[15:0] (increments on each overrun), both saturating at 16'hFFFF, reset to 0.
REQ-028 Without FRAME_SEQ_STATS_EN: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-029 Shared package frame_seq_pkg SHALL hold the FSM state encoding, default FRAME_PERIOD, and stats counter width 16.
REQ-030 Tick counter SHALL be sub-module frame_tick_gen (clk, rst, enable -> tick).

Verification (FRAME_PERIOD=10)
REQ-031 enable=1 from reset release -> tick at cycle 9, frame_start high only at cycle 10, busy high from cycle 10.
REQ-032 raster_done at cycle 15, vsync rise at 20, swap_ack 2 cycles after swap_req -> swap_req within 3 cycles of vsync, front_sel 0->1, IDLE; frame_count=1 (stats).
REQ-033 raster_done withheld 25 cycles -> overrun pulses at ticks 19 and 29, no extra frame_start; drop_count=2.
REQ-034 vsync pulses during RENDER and swap_ack while IDLE -> no state change, front_sel unchanged.
REQ-035 rst asserted in WAIT_VSYNC -> immediate IDLE, outputs zero, front_sel=0; next frame_start 11 cycles after release.
REQ-036 enable dropped in RENDER -> frame completes and swaps; no further tick until enable re-asserted, then first tick 10 cycles later.

Source files
------------

// File: rtl/frame_seq_pkg.sv
// Shared definitions for the frame sequencer: FSM state encoding, default
// frame period, statistics counter width and a saturating increment helper.
package frame_seq_pkg;

  localparam int DEF_FRAME_PERIOD = 1666667;
  localparam int DEF_CNT_W        = 21;
  localparam int STATS_W          = 16;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_START      = 3'd1;
  localparam logic [2:0] ST_RENDER     = 3'd2;
  localparam logic [2:0] ST_WAIT_VSYNC = 3'd3;
  localparam logic [2:0] ST_SWAP       = 3'd4;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == {STATS_W{1'b1}}) ? v : v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame tick generator: counts 0..FRAME_PERIOD-1 while enabled
// and flags the last count; disabling clears the count and suppresses the tick.
module frame_tick_gen
  import frame_seq_pkg::*;
#(
  parameter int FRAME_PERIOD = DEF_FRAME_PERIOD,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_end;

  assign at_end = (cnt_q == CNT_W'(FRAME_PERIOD - 1));
  assign tick   = enable & at_end;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!enable || at_end) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: paces render frames from a periodic tick, waits for the
// rasterizer and display vsync, then hands off a buffer swap. Optional
// statistics outputs (frame_count, drop_count) are built when FRAME_SEQ_STATS_EN is defined.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int FRAME_PERIOD = DEF_FRAME_PERIOD,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic vsync,
  input  logic raster_done,
  input  logic swap_ack,
  output logic frame_start,
  output logic swap_req,
  output logic front_sel,
  output logic busy,
  output logic overrun
`ifdef FRAME_SEQ_STATS_EN
  ,
  output logic [STATS_W-1:0] frame_count,
  output logic [STATS_W-1:0] drop_count
`endif
);

  logic       tick;
  logic [2:0] state_q, state_d;
  logic       vs_meta_q, vs_sync_q, vs_prev_q;
  logic       vs_rise;
  logic       swap_done;
  logic       front_sel_q;

  frame_tick_gen #(
    .FRAME_PERIOD(FRAME_PERIOD),
    .CNT_W       (CNT_W)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .tick  (tick)
  );

  // vsync is asynchronous: two flops for metastability, a third for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_meta_q <= 1'b0;
      vs_sync_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      vs_meta_q <= vsync;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
    end
  end

  assign vs_rise   = vs_sync_q & ~vs_prev_q;
  assign swap_done = (state_q == ST_SWAP) & swap_ack;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (tick) state_d = ST_START;
      ST_START:      state_d = ST_RENDER;
      ST_RENDER:     if (raster_done) state_d = ST_WAIT_VSYNC;
      ST_WAIT_VSYNC: if (vs_rise) state_d = ST_SWAP;
      ST_SWAP:       if (swap_ack) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      front_sel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (swap_done) front_sel_q <= ~front_sel_q;
    end
  end

  assign frame_start = (state_q == ST_START);
  assign swap_req    = (state_q == ST_SWAP);
  assign busy        = (state_q != ST_IDLE);
  // A tick landing while a frame is in flight (including the SWAP exit cycle) is dropped
  assign overrun     = tick & busy;
  assign front_sel   = front_sel_q;

`ifdef FRAME_SEQ_STATS_EN
  logic [STATS_W-1:0] frame_count_q, drop_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      if (swap_done) frame_count_q <= sat_inc(frame_count_q);
      if (overrun)   drop_count_q  <= sat_inc(drop_count_q);
    end
  end

  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed testbench for frame_sequencer with FRAME_PERIOD=10; cycle c counts
// clock periods after reset release, outputs sampled 1ns after the falling edge.
module tb_frame_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0, vsync = 1'b0, raster_done = 1'b0, swap_ack = 1'b0;
  logic frame_start, swap_req, front_sel, busy, overrun;
`ifdef FRAME_SEQ_STATS_EN
  logic [15:0] frame_count, drop_count;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  frame_sequencer #(
    .FRAME_PERIOD(10),
    .CNT_W       (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .vsync      (vsync),
    .raster_done(raster_done),
    .swap_ack   (swap_ack),
    .frame_start(frame_start),
    .swap_req   (swap_req),
    .front_sel  (front_sel),
    .busy       (busy),
    .overrun    (overrun)
`ifdef FRAME_SEQ_STATS_EN
    ,
    .frame_count(frame_count),
    .drop_count (drop_count)
`endif
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; vsync = 1'b0; raster_done = 1'b0; swap_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; enable = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_total++; if ({frame_start, swap_req, front_sel, busy, overrun} !== 5'b0) $display("FAIL reset_outs got=%b exp=00000", {frame_start, swap_req, front_sel, busy, overrun}); else n_pass++;
`ifdef FRAME_SEQ_STATS_EN
    n_total++; if ({frame_count, drop_count} !== 32'h0) $display("FAIL reset_stats got=%h exp=0", {frame_count, drop_count}); else n_pass++;
`endif
  endtask

  task automatic test_frame();
    do_reset();
    for (int c = 0; c <= 26; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c <= 20) begin n_total++; if (frame_start !== (c == 10)) $display("FAIL frame_start c=%0d got=%b exp=%b", c, frame_start, c == 10); else n_pass++; end
      if (c == 9)  begin n_total++; if (busy !== 1'b0) $display("FAIL busy_pre c=%0d got=%b exp=0", c, busy); else n_pass++; end
      if (c == 10) begin n_total++; if (busy !== 1'b1) $display("FAIL busy_start c=%0d got=%b exp=1", c, busy); else n_pass++; end
      if (c >= 11) begin n_total++; if (overrun !== (c == 19)) $display("FAIL overrun c=%0d got=%b exp=%b", c, overrun, c == 19); else n_pass++; end
      if (c == 22) begin n_total++; if (swap_req !== 1'b0) $display("FAIL swap_req_early c=%0d got=%b exp=0", c, swap_req); else n_pass++; end
      if (c == 23 || c == 25) begin n_total++; if ({swap_req, front_sel} !== 2'b10) $display("FAIL swap_req_hold c=%0d got=%b exp=10", c, {swap_req, front_sel}); else n_pass++; end
      if (c == 26) begin
        n_total++; if ({swap_req, busy, front_sel} !== 3'b001) $display("FAIL swap_done c=%0d got=%b exp=001", c, {swap_req, busy, front_sel}); else n_pass++;
`ifdef FRAME_SEQ_STATS_EN
        n_total++; if (frame_count !== 16'd1 || drop_count !== 16'd1) $display("FAIL stats_frame got=%0d/%0d exp=1/1", frame_count, drop_count); else n_pass++;
`endif
      end
      if (c == 15) raster_done = 1'b1;
      if (c == 16) raster_done = 1'b0;
      if (c == 20) vsync = 1'b1;
      if (c == 25) swap_ack = 1'b1;
      if (c == 26) begin swap_ack = 1'b0; vsync = 1'b0; end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int c = 0; c <= 36; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_total++; if (frame_start !== (c == 10)) $display("FAIL ovr_frame_start c=%0d got=%b exp=%b", c, frame_start, c == 10); else n_pass++;
      if (c >= 1 && c <= 9) begin n_total++; if (busy !== 1'b0) $display("FAIL ovr_idle_busy c=%0d got=%b exp=0", c, busy); else n_pass++; end
      if (c >= 11 && c <= 35) begin
        n_total++; if (overrun !== (c == 19 || c == 29)) $display("FAIL ovr_pulse c=%0d got=%b exp=%b", c, overrun, c == 19 || c == 29); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL ovr_busy c=%0d got=%b exp=1", c, busy); else n_pass++;
      end
      if (c == 36) begin
        n_total++; if ({busy, swap_req} !== 2'b10) $display("FAIL ovr_wait c=%0d got=%b exp=10", c, {busy, swap_req}); else n_pass++;
`ifdef FRAME_SEQ_STATS_EN
        n_total++; if (drop_count !== 16'd2 || frame_count !== 16'd0) $display("FAIL stats_drop got=%0d/%0d exp=0/2", frame_count, drop_count); else n_pass++;
`endif
      end
      if (c == 3 || c == 10 || c == 35) raster_done = 1'b1;
      if (c == 4 || c == 11 || c == 36) raster_done = 1'b0;
    end
  endtask

  task automatic test_ignore();
    do_reset();
    for (int c = 0; c <= 28; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c >= 1 && c <= 9) begin n_total++; if ({busy, front_sel, swap_req} !== 3'b000) $display("FAIL ign_idle c=%0d got=%b exp=000", c, {busy, front_sel, swap_req}); else n_pass++; end
      if (c == 10) begin n_total++; if (frame_start !== 1'b1) $display("FAIL ign_start c=%0d got=%b exp=1", c, frame_start); else n_pass++; end
      if (c >= 12 && c <= 18) begin n_total++; if ({busy, swap_req} !== 2'b10) $display("FAIL ign_render c=%0d got=%b exp=10", c, {busy, swap_req}); else n_pass++; end
      if (c >= 19 && c <= 27) begin n_total++; if ({busy, swap_req} !== 2'b10) $display("FAIL ign_wait c=%0d got=%b exp=10", c, {busy, swap_req}); else n_pass++; end
      if (c == 24) begin n_total++; if (front_sel !== 1'b0) $display("FAIL ign_front c=%0d got=%b exp=0", c, front_sel); else n_pass++; end
      if (c == 28) begin n_total++; if ({swap_req, front_sel} !== 2'b10) $display("FAIL ign_swap c=%0d got=%b exp=10", c, {swap_req, front_sel}); else n_pass++; end
      if (c == 2 || c == 22) swap_ack = 1'b1;
      if (c == 4 || c == 23) swap_ack = 1'b0;
      if (c == 12 || c == 25) vsync = 1'b1;
      if (c == 15) vsync = 1'b0;
      if (c == 18) raster_done = 1'b1;
      if (c == 19) raster_done = 1'b0;
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    for (int c = 0; c <= 35; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c == 24) begin n_total++; if ({front_sel, busy} !== 2'b10) $display("FAIL rm_first c=%0d got=%b exp=10", c, {front_sel, busy}); else n_pass++; end
      if (c == 30) begin n_total++; if (frame_start !== 1'b1) $display("FAIL rm_start2 c=%0d got=%b exp=1", c, frame_start); else n_pass++; end
      if (c == 35) begin n_total++; if ({busy, front_sel, swap_req} !== 3'b110) $display("FAIL rm_wait c=%0d got=%b exp=110", c, {busy, front_sel, swap_req}); else n_pass++; end
      if (c == 15 || c == 32) raster_done = 1'b1;
      if (c == 16 || c == 33) raster_done = 1'b0;
      if (c == 20) vsync = 1'b1;
      if (c == 26) vsync = 1'b0;
      if (c == 23) swap_ack = 1'b1;
      if (c == 24) swap_ack = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    n_total++; if ({frame_start, swap_req, front_sel, busy, overrun} !== 5'b0) $display("FAIL rm_async got=%b exp=00000", {frame_start, swap_req, front_sel, busy, overrun}); else n_pass++;
`ifdef FRAME_SEQ_STATS_EN
    n_total++; if ({frame_count, drop_count} !== 32'h0) $display("FAIL rm_stats got=%h exp=0", {frame_count, drop_count}); else n_pass++;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0; enable = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_total++; if ({frame_start, swap_req} !== {c == 10, 1'b0}) $display("FAIL rm_restart c=%0d got=%b exp=%b0", c, {frame_start, swap_req}, c == 10); else n_pass++;
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    for (int c = 0; c <= 50; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c == 17) begin n_total++; if (swap_req !== 1'b0) $display("FAIL ed_pre_swap c=%0d got=%b exp=0", c, swap_req); else n_pass++; end
      if (c == 18) begin n_total++; if (swap_req !== 1'b1) $display("FAIL ed_swap c=%0d got=%b exp=1", c, swap_req); else n_pass++; end
      if (c == 19) begin n_total++; if ({front_sel, busy, swap_req} !== 3'b100) $display("FAIL ed_done c=%0d got=%b exp=100", c, {front_sel, busy, swap_req}); else n_pass++; end
      if (c >= 12) begin n_total++; if (overrun !== 1'b0) $display("FAIL ed_overrun c=%0d got=%b exp=0", c, overrun); else n_pass++; end
      if (c >= 11) begin n_total++; if (frame_start !== (c == 50)) $display("FAIL ed_frame_start c=%0d got=%b exp=%b", c, frame_start, c == 50); else n_pass++; end
      if (c == 12) enable = 1'b0;
      if (c == 13) raster_done = 1'b1;
      if (c == 14) raster_done = 1'b0;
      if (c == 15) vsync = 1'b1;
      if (c == 20) vsync = 1'b0;
      if (c == 18) swap_ack = 1'b1;
      if (c == 19) swap_ack = 1'b0;
      if (c == 40) enable = 1'b1;
    end
  endtask

  task automatic test_swap_tick_collision();
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c == 17) begin n_total++; if (swap_req !== 1'b1) $display("FAIL col_swap c=%0d got=%b exp=1", c, swap_req); else n_pass++; end
      if (c == 19) begin n_total++; if ({overrun, swap_req} !== 2'b11) $display("FAIL col_overrun c=%0d got=%b exp=11", c, {overrun, swap_req}); else n_pass++; end
      if (c == 20) begin
        n_total++; if ({busy, front_sel, swap_req} !== 3'b010) $display("FAIL col_idle c=%0d got=%b exp=010", c, {busy, front_sel, swap_req}); else n_pass++;
`ifdef FRAME_SEQ_STATS_EN
        n_total++; if (frame_count !== 16'd1 || drop_count !== 16'd1) $display("FAIL col_stats got=%0d/%0d exp=1/1", frame_count, drop_count); else n_pass++;
`endif
      end
      if (c >= 20) begin n_total++; if (frame_start !== (c == 30)) $display("FAIL col_frame_start c=%0d got=%b exp=%b", c, frame_start, c == 30); else n_pass++; end
      if (c == 11) raster_done = 1'b1;
      if (c == 12) raster_done = 1'b0;
      if (c == 14) vsync = 1'b1;
      if (c == 22) vsync = 1'b0;
      if (c == 19) swap_ack = 1'b1;
      if (c == 20) swap_ack = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame();
    test_overrun();
    test_ignore();
    test_rst_mid();
    test_enable_drop();
    test_swap_tick_collision();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
